fft_frame_sched: RTL and testbench
==================================

Name: fft_frame_sched

Overview:
- Frame-granular scheduler that shares one fft_demo_00 core between two AXI4-Stream frame sources (ch0, ch1).
- For each frame: grants one source round-robin, issues the core's one-beat cfg (direction), passes exactly 2^LOG2_FFT_LEN beats, forces tlast.
- Records each frame's source in a tag FIFO so every xk output frame is labelled with its originating channel.
- Sits between the frame generators/DMA and the FFT wrapper; alarm/error outputs feed the top-level error lock.

Parameters:
- DATA_WIDTH, 32, complex input beat width (imag in upper half, real in lower half), passed through unmodified.
- LOG2_FFT_LEN, 3, log2 of frame length N; beat counter width is LOG2_FFT_LEN.
- TAG_DEPTH, 4, maximum frames in flight inside the core (power of 2, >=2).

Ports:
- i_clk  in  1  clock.
- srstn  in  1  reset, asynchronous, active-low.
- i_aclken  in  1  clock enable; all state advances only when high.
- i_ch0_tvalid / i_ch1_tvalid  in  1  source beat valid.
- i_ch0_tdata / i_ch1_tdata  in  DATA_WIDTH  source beat data.
- i_ch0_tlast / i_ch1_tlast  in  1  source end-of-frame marker.
- i_ch0_inv / i_ch1_inv  in  1  1 = inverse FFT requested; sampled at grant.
- o_ch0_tready / o_ch1_tready  out  1  source ready.
- o_fft_tvalid  out  1  beat valid to the core.
- o_fft_tdata  out  DATA_WIDTH  beat data to the core.
- o_fft_tlast  out  1  end-of-frame to the core.
- i_fft_tready  in  1  core ready.
- o_cfg_tvalid  out  1  core cfg strobe.
- o_cfg_tdata  out  1  1 = forward, 0 = inverse.
- i_xk_tvalid  in  1  core output beat valid.
- i_xk_tlast  in  1  core output end-of-frame.
- o_xk_chan  out  1  source channel of the current output frame (FIFO head).
- o_xk_tag_valid  out  1  tag FIFO not empty.
- o_len_err  out  1  one-cycle pulse on frame-length mismatch.
- o_ovf  out  1  sticky: output beat seen with empty tag FIFO.
- o_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, last_grant=1 (ch0 wins the first tie), tag FIFO empty, beat counter 0.
- Reset mid-frame: frame abandoned, no tag pushed; the core's own reset is the system's responsibility.
- i_aclken=0: all registers hold; o_fft_tvalid, o_chX_tready and o_cfg_tvalid are forced 0.
- FSM IDLE:
  - If FIFO count < TAG_DEPTH and any i_chX_tvalid, grant: sole requester, or on a tie the channel != last_grant.
  - Latch grant and that channel's inv, then go to CFG.
  - If the FIFO is full, no grant is made.
- FSM CFG (one enabled cycle): o_cfg_tvalid=1, o_cfg_tdata=~inv_latched; next state XFER. No source beat is accepted in IDLE or CFG.
- FSM XFER:
  - Combinational pass-through: o_fft_tvalid = granted tvalid & aclken; o_fft_tdata = granted tdata.
  - o_chG_tready = i_fft_tready & aclken; the non-granted tready = 0.
  - Handshake = o_fft_tvalid & i_fft_tready; the counter increments per handshake.
  - o_fft_tlast = (cnt == N-1), independent of the input tlast.
  - On the handshake with cnt==N-1: push grant to the tag FIFO, set last_grant=grant, cnt=0, return to IDLE.
- o_len_err pulses for one cycle on any handshake where input tlast != (cnt==N-1).
  - Early tlast: the frame still runs to N beats.
  - Late or missing tlast: the frame is still closed at N.
- Minimum frame overhead is 2 cycles (IDLE, CFG); back-to-back frames alternate channels when both are requesting.
- Tag FIFO: push as above; pop on i_xk_tvalid & i_xk_tlast & aclken with the FIFO non-empty.
  - Simultaneous push and pop: count is unchanged and data stays correct.
  - o_xk_chan and o_xk_tag_valid are driven from the registered head and count.
- i_xk_tvalid with an empty FIFO sets o_ovf, which is held until reset; no pop occurs.
- o_busy = (state != IDLE).

Test Plan:
- Only ch0 sends one 8-beat frame (inv=0), tready=1 → cfg_tvalid pulses once with cfg_tdata=1; 8 beats pass with tlast on beat 8; FIFO count=1, o_xk_chan=0.
- Both channels request continuously for 4 frames → grant order ch0,ch1,ch0,ch1; cfg_tdata follows each channel's inv; o_ch1_tready stays 0 during ch0 frames.
- ch1 asserts tlast on beat 5 → o_len_err pulses once at beat 5; the frame still carries 8 beats, tlast on beat 8.
- 4 frames queued, no xk output → 5th request stalls in IDLE with tready=0; one xk tlast pops a tag and the 5th frame is granted.
- Random i_fft_tready and i_aclken toggling → no beats lost or duplicated; a push and a pop in the same cycle leave the count unchanged.
- i_xk_tvalid with an empty FIFO → o_ovf goes to 1 and stays until srstn; srstn asserted during XFER beat 3 → all outputs 0, FIFO empty.

Source files
------------

// File: rtl/fft_frame_sched_if.sv
// fft_frame_sched_if
//   Bundles every non-clock/reset signal of fft_frame_sched: the clock
//   enable, the two AXI4-Stream frame sources, the stream and cfg channels
//   towards the FFT core, the core's output-frame markers and the
//   status/alarm outputs.
//   Signal names keep their i_/o_ prefixes as seen from the scheduler.
//   Modports:
//     slave  - the scheduler itself (i_* are inputs, o_* are outputs)
//     master - the environment around it (sources, core, error lock)
interface fft_frame_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_aclken;
  logic                  i_ch0_tvalid;
  logic [DATA_WIDTH-1:0] i_ch0_tdata;
  logic                  i_ch0_tlast;
  logic                  i_ch0_inv;
  logic                  i_ch1_tvalid;
  logic [DATA_WIDTH-1:0] i_ch1_tdata;
  logic                  i_ch1_tlast;
  logic                  i_ch1_inv;
  logic                  o_ch0_tready;
  logic                  o_ch1_tready;
  logic                  o_fft_tvalid;
  logic [DATA_WIDTH-1:0] o_fft_tdata;
  logic                  o_fft_tlast;
  logic                  i_fft_tready;
  logic                  o_cfg_tvalid;
  logic                  o_cfg_tdata;
  logic                  i_xk_tvalid;
  logic                  i_xk_tlast;
  logic                  o_xk_chan;
  logic                  o_xk_tag_valid;
  logic                  o_len_err;
  logic                  o_ovf;
  logic                  o_busy;

  modport slave (
    input  i_aclken,
    input  i_ch0_tvalid, i_ch0_tdata, i_ch0_tlast, i_ch0_inv,
    input  i_ch1_tvalid, i_ch1_tdata, i_ch1_tlast, i_ch1_inv,
    output o_ch0_tready, o_ch1_tready,
    output o_fft_tvalid, o_fft_tdata, o_fft_tlast,
    input  i_fft_tready,
    output o_cfg_tvalid, o_cfg_tdata,
    input  i_xk_tvalid, i_xk_tlast,
    output o_xk_chan, o_xk_tag_valid, o_len_err, o_ovf, o_busy
  );

  modport master (
    output i_aclken,
    output i_ch0_tvalid, i_ch0_tdata, i_ch0_tlast, i_ch0_inv,
    output i_ch1_tvalid, i_ch1_tdata, i_ch1_tlast, i_ch1_inv,
    input  o_ch0_tready, o_ch1_tready,
    input  o_fft_tvalid, o_fft_tdata, o_fft_tlast,
    output i_fft_tready,
    input  o_cfg_tvalid, o_cfg_tdata,
    output i_xk_tvalid, i_xk_tlast,
    input  o_xk_chan, o_xk_tag_valid, o_len_err, o_ovf, o_busy
  );
endinterface

// File: rtl/fft_frame_sched.sv
// fft_frame_sched
//   Shares one FFT core between two AXI4-Stream frame sources. Each frame
//   is granted round-robin to one source, preceded by a one-beat cfg
//   (1 = forward, 0 = inverse), passed through for exactly 2^LOG2_FFT_LEN
//   beats with tlast regenerated, and its source channel is queued in a tag
//   FIFO so the core's output frames can be labelled.
//   Ports:
//     i_clk  - clock
//     srstn  - asynchronous active-low reset
//     bus    - fft_frame_sched_if.slave: clock enable, ch0/ch1 sources,
//              core stream + cfg, core output frame markers, status
//              (o_xk_chan, o_xk_tag_valid, o_len_err, o_ovf, o_busy)
module fft_frame_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int LOG2_FFT_LEN = 3,
  parameter int TAG_DEPTH    = 4
) (
  input  logic                i_clk,
  input  logic                srstn,
  fft_frame_sched_if.slave    bus
);

  localparam int PW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t                  state;
  logic                    grant;
  logic                    inv_latched;
  logic                    last_grant;
  logic [LOG2_FFT_LEN-1:0] cnt;

  logic                    tag_mem [TAG_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW:0]             tag_cnt;
  logic                    ovf;

  logic                    g_tvalid;
  logic [DATA_WIDTH-1:0]   g_tdata;
  logic                    g_tlast;
  logic                    in_xfer;
  logic                    fft_tvalid;
  logic                    hs;
  logic                    last_beat;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    next_grant;
  logic                    any_req;

  // Mux of the currently granted source.
  assign g_tvalid = grant ? bus.i_ch1_tvalid : bus.i_ch0_tvalid;
  assign g_tdata  = grant ? bus.i_ch1_tdata  : bus.i_ch0_tdata;
  assign g_tlast  = grant ? bus.i_ch1_tlast  : bus.i_ch0_tlast;

  assign in_xfer    = (state == ST_XFER);
  assign fft_tvalid = in_xfer & g_tvalid & bus.i_aclken;
  assign hs         = fft_tvalid & bus.i_fft_tready;
  assign last_beat  = (cnt == '1);

  assign fifo_empty = (tag_cnt == '0);
  assign fifo_full  = (tag_cnt == (PW+1)'(TAG_DEPTH));
  assign push       = hs & last_beat;
  assign pop        = bus.i_aclken & bus.i_xk_tvalid & bus.i_xk_tlast & ~fifo_empty;

  // On a tie the channel that did not win last time is granted.
  assign any_req    = bus.i_ch0_tvalid | bus.i_ch1_tvalid;
  assign next_grant = (bus.i_ch0_tvalid & bus.i_ch1_tvalid) ? ~last_grant : bus.i_ch1_tvalid;

  assign bus.o_fft_tvalid   = fft_tvalid;
  assign bus.o_fft_tdata    = in_xfer ? g_tdata : '0;
  assign bus.o_fft_tlast    = in_xfer & last_beat;
  assign bus.o_ch0_tready   = in_xfer & ~grant & bus.i_fft_tready & bus.i_aclken;
  assign bus.o_ch1_tready   = in_xfer &  grant & bus.i_fft_tready & bus.i_aclken;
  assign bus.o_cfg_tvalid   = (state == ST_CFG) & bus.i_aclken;
  assign bus.o_cfg_tdata    = (state == ST_CFG) & ~inv_latched;
  // The frame length is fixed by the counter; tlast from the source is only
  // checked against it, never used to end the frame.
  assign bus.o_len_err      = hs & (g_tlast != last_beat);
  assign bus.o_xk_tag_valid = ~fifo_empty;
  assign bus.o_xk_chan      = ~fifo_empty & tag_mem[rd_ptr];
  assign bus.o_ovf          = ovf;
  assign bus.o_busy         = (state != ST_IDLE);

  // Frame FSM: grant, cfg beat, then N data beats.
  always_ff @(posedge i_clk or negedge srstn) begin
    if (!srstn) begin
      state       <= ST_IDLE;
      grant       <= 1'b0;
      inv_latched <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
    end else if (bus.i_aclken) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_full && any_req) begin
            grant       <= next_grant;
            inv_latched <= next_grant ? bus.i_ch1_inv : bus.i_ch0_inv;
            state       <= ST_CFG;
          end
        end
        ST_CFG: begin
          state <= ST_XFER;
        end
        ST_XFER: begin
          if (hs) begin
            if (last_beat) begin
              cnt        <= '0;
              last_grant <= grant;
              state      <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag FIFO of frame source channels; a push and pop in the same cycle
  // leave the occupancy unchanged. Pointers wrap since TAG_DEPTH is 2^PW.
  always_ff @(posedge i_clk or negedge srstn) begin
    if (!srstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
      ovf     <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
      // Core output with nothing outstanding: sticky until reset.
      if (bus.i_aclken && bus.i_xk_tvalid && fifo_empty) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched
//   Directed self-checking bench for fft_frame_sched. Sources emit
//   recognisable data words {0xA0+ch, frame, 0x5A, beat}; a per-cycle
//   driver/monitor logs cfg beats, core beats and len_err pulses, and each
//   test task compares those logs against hand-computed expectations.
module tb_fft_frame_sched;

  localparam int DW = 32;

  logic i_clk = 1'b0;
  logic srstn = 1'b0;

  fft_frame_sched_if #(.DATA_WIDTH(DW)) bus ();

  fft_frame_sched #(
    .DATA_WIDTH(DW),
    .LOG2_FFT_LEN(3),
    .TAG_DEPTH(4)
  ) dut (
    .i_clk(i_clk),
    .srstn(srstn),
    .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  int         src_left  [2];
  int         src_frame [2];
  int         src_beat  [2];
  bit         src_inv   [2][8];
  logic [7:0] src_tl    [2][8];
  bit         rnd_mode;
  bit         xk_v;
  bit         xk_l;

  logic [31:0] beat_data [$];
  bit          beat_last [$];
  int          beat_cyc  [$];
  int          lenerr_idx[$];
  bit          cfg_data  [$];
  int          cfg_cyc   [$];
  int          both_leak;
  int          gate_leak;
  int          cyc;

  function automatic logic [31:0] pattern(int ch, int fr, int b);
    return {8'hA0 + 8'(ch), 8'(fr), 8'h5A, 8'(b)};
  endfunction

  task automatic zero_inputs();
    bus.i_aclken     = 1'b0;
    bus.i_ch0_tvalid = 1'b0; bus.i_ch0_tdata = '0; bus.i_ch0_tlast = 1'b0; bus.i_ch0_inv = 1'b0;
    bus.i_ch1_tvalid = 1'b0; bus.i_ch1_tdata = '0; bus.i_ch1_tlast = 1'b0; bus.i_ch1_inv = 1'b0;
    bus.i_fft_tready = 1'b0;
    bus.i_xk_tvalid  = 1'b0;
    bus.i_xk_tlast   = 1'b0;
  endtask

  task automatic clear_tb();
    for (int c = 0; c < 2; c++) begin
      src_left[c] = 0; src_frame[c] = 0; src_beat[c] = 0;
      for (int f = 0; f < 8; f++) begin
        src_inv[c][f] = 1'b0;
        src_tl[c][f]  = 8'h80;
      end
    end
    rnd_mode = 1'b0; xk_v = 1'b0; xk_l = 1'b0;
    beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    lenerr_idx.delete(); cfg_data.delete(); cfg_cyc.delete();
    both_leak = 0; gate_leak = 0; cyc = 0;
  endtask

  task automatic do_reset();
    clear_tb();
    @(negedge i_clk);
    srstn = 1'b0;
    zero_inputs();
    repeat (2) @(negedge i_clk);
    srstn = 1'b1;
  endtask

  // One clock: drive sources/core/xk at the falling edge, sample 1 ns later,
  // log what the next rising edge will commit and advance the sources.
  task automatic cycle();
    bit acl, rdy, v0, v1;
    int f0, f1;
    @(negedge i_clk);
    acl = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    rdy = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    f0  = src_frame[0] % 8;
    f1  = src_frame[1] % 8;
    v0  = (src_left[0] > 0);
    v1  = (src_left[1] > 0);
    bus.i_aclken     = acl;
    bus.i_fft_tready = rdy;
    bus.i_ch0_tvalid = v0;
    bus.i_ch0_tdata  = pattern(0, src_frame[0], src_beat[0]);
    bus.i_ch0_tlast  = src_tl[0][f0][src_beat[0] % 8];
    bus.i_ch0_inv    = src_inv[0][f0];
    bus.i_ch1_tvalid = v1;
    bus.i_ch1_tdata  = pattern(1, src_frame[1], src_beat[1]);
    bus.i_ch1_tlast  = src_tl[1][f1][src_beat[1] % 8];
    bus.i_ch1_inv    = src_inv[1][f1];
    bus.i_xk_tvalid  = xk_v;
    bus.i_xk_tlast   = xk_l;
    #1;
    if (bus.o_cfg_tvalid) begin
      cfg_data.push_back(bus.o_cfg_tdata);
      cfg_cyc.push_back(cyc);
    end
    if (bus.o_len_err) lenerr_idx.push_back(beat_data.size());
    if (bus.o_fft_tvalid && rdy) begin
      beat_data.push_back(bus.o_fft_tdata);
      beat_last.push_back(bus.o_fft_tlast);
      beat_cyc.push_back(cyc);
    end
    if (bus.o_ch0_tready && bus.o_ch1_tready) both_leak++;
    if (!acl && (bus.o_ch0_tready || bus.o_ch1_tready || bus.o_fft_tvalid || bus.o_cfg_tvalid))
      gate_leak++;
    if (v0 && bus.o_ch0_tready) begin
      src_beat[0]++;
      if (src_beat[0] == 8) begin src_beat[0] = 0; src_frame[0]++; src_left[0]--; end
    end
    if (v1 && bus.o_ch1_tready) begin
      src_beat[1]++;
      if (src_beat[1] == 8) begin src_beat[1] = 0; src_frame[1]++; src_left[1]--; end
    end
    cyc++;
  endtask

  task automatic run_beats(int n, int budget);
    int k = 0;
    while (beat_data.size() < n && k < budget) begin
      cycle();
      k++;
    end
  endtask

  task automatic idle_cycles(int n);
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    clear_tb();
    srstn = 1'b0;
    zero_inputs();
    bus.i_aclken = 1'b1; bus.i_ch0_tvalid = 1'b1; bus.i_xk_tvalid = 1'b1; bus.i_fft_tready = 1'b1;
    repeat (2) @(negedge i_clk);
    #1;
    outs = {bus.o_ch0_tready, bus.o_ch1_tready, bus.o_fft_tvalid, bus.o_fft_tlast, bus.o_cfg_tvalid,
            bus.o_cfg_tdata, bus.o_xk_chan, bus.o_xk_tag_valid, bus.o_len_err, bus.o_ovf, bus.o_busy};
    n_checks++;
    if (outs !== 11'd0) begin n_fail++; $display("[TB] FAIL reset_outputs: got %b expected 0", outs); end
    n_checks++;
    if (bus.o_fft_tdata !== '0) begin n_fail++; $display("[TB] FAIL reset_tdata: got %h expected 0", bus.o_fft_tdata); end
    zero_inputs();
    @(negedge i_clk);
    srstn = 1'b1;
  endtask

  task automatic test_single_frame();
    int errs = 0;
    logic [7:0] lmask = '0;
    do_reset();
    src_left[0] = 1;
    run_beats(8, 40);
    idle_cycles(2);
    n_checks++;
    if (cfg_data.size() != 1) begin n_fail++; $display("[TB] FAIL single_cfg_count: got %0d expected 1", cfg_data.size()); end
    n_checks++;
    if (cfg_data.size() > 0 && (cfg_data[0] !== 1'b1 || cfg_cyc[0] != 1)) begin
      n_fail++; $display("[TB] FAIL single_cfg: got data %0d cycle %0d expected data 1 cycle 1", cfg_data[0], cfg_cyc[0]);
    end
    n_checks++;
    if (beat_data.size() != 8) begin n_fail++; $display("[TB] FAIL single_beats: got %0d expected 8", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 8; i++) begin
      if (beat_data[i] !== pattern(0, 0, i)) errs++;
      lmask[i] = beat_last[i];
    end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("[TB] FAIL single_data: got %0d bad beats expected 0", errs); end
    n_checks++;
    if (lmask !== 8'h80) begin n_fail++; $display("[TB] FAIL single_tlast: got %b expected 10000000", lmask); end
    n_checks++;
    if (beat_cyc.size() > 0 && beat_cyc[0] != 2) begin
      n_fail++; $display("[TB] FAIL single_latency: got %0d expected 2", beat_cyc[0]);
    end
    n_checks++;
    if (lenerr_idx.size() != 0) begin n_fail++; $display("[TB] FAIL single_len_err: got %0d pulses expected 0", lenerr_idx.size()); end
    n_checks++;
    if ({bus.o_xk_tag_valid, bus.o_xk_chan, bus.o_busy} !== 3'b100) begin
      n_fail++; $display("[TB] FAIL single_tag: got valid/chan/busy %b expected 100", {bus.o_xk_tag_valid, bus.o_xk_chan, bus.o_busy});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order = '0, cfgs = '0, chans = '0, valids = '0;
    int errs = 0, gaps = 0;
    do_reset();
    src_left[0] = 2; src_left[1] = 2;
    src_inv[0][0] = 1'b1; src_inv[0][1] = 1'b0;
    src_inv[1][0] = 1'b0; src_inv[1][1] = 1'b1;
    run_beats(32, 200);
    idle_cycles(2);
    n_checks++;
    if (beat_data.size() != 32 || cfg_data.size() != 4) begin
      n_fail++; $display("[TB] FAIL rr_counts: got %0d beats %0d cfgs expected 32 and 4", beat_data.size(), cfg_data.size());
    end
    for (int f = 0; f < 4 && f < cfg_data.size(); f++) cfgs[f] = cfg_data[f];
    for (int i = 0; i < beat_data.size() && i < 32; i++) begin
      if (i % 8 == 0) order[i/8] = beat_data[i][24];
      if (beat_data[i] !== pattern(i/8 % 2, i/16, i % 8)) errs++;
      if (i > 0 && i % 8 == 0 && beat_cyc[i] - beat_cyc[i-1] != 3) gaps++;
    end
    n_checks++;
    if (order !== 4'b1010) begin n_fail++; $display("[TB] FAIL rr_order: got %b expected 1010", order); end
    n_checks++;
    if (cfgs !== 4'b0110) begin n_fail++; $display("[TB] FAIL rr_cfg: got %b expected 0110", cfgs); end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("[TB] FAIL rr_data: got %0d bad beats expected 0", errs); end
    n_checks++;
    if (gaps != 0) begin n_fail++; $display("[TB] FAIL rr_overhead: got %0d frame gaps not 2 cycles expected 0", gaps); end
    n_checks++;
    if (both_leak != 0) begin n_fail++; $display("[TB] FAIL rr_ready_leak: got %0d expected 0", both_leak); end
    for (int k = 0; k < 4; k++) begin
      xk_v = 1'b1; xk_l = 1'b1;
      cycle();
      chans[k]  = bus.o_xk_chan;
      valids[k] = bus.o_xk_tag_valid;
    end
    xk_v = 1'b0; xk_l = 1'b0;
    cycle();
    n_checks++;
    if ({valids, chans} !== 8'b1111_1010) begin
      n_fail++; $display("[TB] FAIL rr_tags: got valid %b chan %b expected 1111 1010", valids, chans);
    end
    n_checks++;
    if ({bus.o_xk_tag_valid, bus.o_ovf} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL rr_drained: got valid/ovf %b expected 00", {bus.o_xk_tag_valid, bus.o_ovf});
    end
  endtask

  task automatic test_len_err();
    logic [15:0] lmask = '0;
    int got0, got1;
    do_reset();
    src_left[1] = 2;
    src_tl[1][0] = 8'b1001_0000;
    src_tl[1][1] = 8'h00;
    run_beats(16, 100);
    idle_cycles(2);
    for (int i = 0; i < beat_data.size() && i < 16; i++) lmask[i] = beat_last[i];
    n_checks++;
    if (beat_data.size() != 16) begin n_fail++; $display("[TB] FAIL len_beats: got %0d expected 16", beat_data.size()); end
    n_checks++;
    if (lmask !== 16'h8080) begin n_fail++; $display("[TB] FAIL len_tlast: got %h expected 8080", lmask); end
    got0 = (lenerr_idx.size() > 0) ? lenerr_idx[0] : -1;
    got1 = (lenerr_idx.size() > 1) ? lenerr_idx[1] : -1;
    n_checks++;
    if (lenerr_idx.size() != 2 || got0 != 4 || got1 != 15) begin
      n_fail++; $display("[TB] FAIL len_err_pulses: got %0d pulses at %0d,%0d expected 2 at 4,15", lenerr_idx.size(), got0, got1);
    end
  endtask

  task automatic test_fifo_full();
    int pop_cyc;
    do_reset();
    src_left[0] = 5;
    run_beats(32, 200);
    idle_cycles(10);
    n_checks++;
    if (beat_data.size() != 32 || cfg_data.size() != 4) begin
      n_fail++; $display("[TB] FAIL full_stall_counts: got %0d beats %0d cfgs expected 32 and 4", beat_data.size(), cfg_data.size());
    end
    n_checks++;
    if ({bus.o_busy, bus.o_ch0_tready, bus.o_xk_tag_valid} !== 3'b001) begin
      n_fail++; $display("[TB] FAIL full_stall_state: got busy/tready/tagv %b expected 001",
                          {bus.o_busy, bus.o_ch0_tready, bus.o_xk_tag_valid});
    end
    xk_v = 1'b1; xk_l = 1'b1;
    pop_cyc = cyc;
    cycle();
    xk_v = 1'b0; xk_l = 1'b0;
    run_beats(40, 60);
    n_checks++;
    if (beat_data.size() != 40 || cfg_data.size() != 5) begin
      n_fail++; $display("[TB] FAIL full_resume_counts: got %0d beats %0d cfgs expected 40 and 5", beat_data.size(), cfg_data.size());
    end
    n_checks++;
    if (beat_data.size() > 32 && (beat_data[32] !== pattern(0, 4, 0) || beat_cyc[32] != pop_cyc + 3)) begin
      n_fail++; $display("[TB] FAIL full_resume_first: got %h at cycle %0d expected %h at cycle %0d",
                          beat_data[32], beat_cyc[32], pattern(0, 4, 0), pop_cyc + 3);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    do_reset();
    src_left[1] = 1;
    run_beats(8, 40);
    idle_cycles(2);
    src_left[0] = 1;
    while (beat_data.size() < 16 && k < 40) begin
      xk_v = (src_left[0] > 0 && src_beat[0] == 7);
      xk_l = xk_v;
      cycle();
      k++;
    end
    xk_v = 1'b0; xk_l = 1'b0;
    idle_cycles(1);
    n_checks++;
    if ({bus.o_xk_tag_valid, bus.o_xk_chan} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL pushpop_head: got valid/chan %b expected 10", {bus.o_xk_tag_valid, bus.o_xk_chan});
    end
    xk_v = 1'b1; xk_l = 1'b1;
    cycle();
    xk_v = 1'b0; xk_l = 1'b0;
    cycle();
    n_checks++;
    if ({bus.o_xk_tag_valid, bus.o_ovf} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL pushpop_count: got valid/ovf %b expected 00", {bus.o_xk_tag_valid, bus.o_ovf});
    end
  endtask

  task automatic test_random_stall();
    int errs = 0;
    do_reset();
    rnd_mode = 1'b1;
    src_left[0] = 2; src_left[1] = 2;
    run_beats(32, 2000);
    rnd_mode = 1'b0;
    idle_cycles(3);
    n_checks++;
    if (beat_data.size() != 32) begin n_fail++; $display("[TB] FAIL rand_beats: got %0d expected 32", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 32; i++) begin
      if (beat_data[i] !== pattern(i/8 % 2, i/16, i % 8)) errs++;
      if (beat_last[i] !== (i % 8 == 7)) errs++;
    end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("[TB] FAIL rand_data: got %0d bad beats expected 0", errs); end
    n_checks++;
    if (gate_leak != 0 || both_leak != 0) begin
      n_fail++; $display("[TB] FAIL rand_gating: got %0d gated %0d dual-ready cycles expected 0", gate_leak, both_leak);
    end
    n_checks++;
    if (lenerr_idx.size() != 0 || cfg_data.size() != 4) begin
      n_fail++; $display("[TB] FAIL rand_frames: got %0d len_err %0d cfgs expected 0 and 4", lenerr_idx.size(), cfg_data.size());
    end
  endtask

  task automatic test_ovf_reset();
    logic [10:0] outs;
    do_reset();
    xk_v = 1'b1; xk_l = 1'b0;
    cycle();
    xk_v = 1'b0;
    idle_cycles(3);
    n_checks++;
    if ({bus.o_ovf, bus.o_xk_tag_valid} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL ovf_sticky: got ovf/tagv %b expected 10", {bus.o_ovf, bus.o_xk_tag_valid});
    end
    src_left[0] = 1;
    run_beats(3, 20);
    n_checks++;
    if (bus.o_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_midframe_busy: got %0d expected 1", bus.o_busy); end
    @(negedge i_clk);
    #2 srstn = 1'b0;
    #1;
    outs = {bus.o_ch0_tready, bus.o_ch1_tready, bus.o_fft_tvalid, bus.o_fft_tlast, bus.o_cfg_tvalid,
            bus.o_cfg_tdata, bus.o_xk_chan, bus.o_xk_tag_valid, bus.o_len_err, bus.o_ovf, bus.o_busy};
    n_checks++;
    if (outs !== 11'd0 || bus.o_fft_tdata !== '0) begin
      n_fail++; $display("[TB] FAIL midframe_reset: got %b tdata %h expected 0", outs, bus.o_fft_tdata);
    end
    clear_tb();
    zero_inputs();
    @(negedge i_clk);
    srstn = 1'b1;
    idle_cycles(12);
    n_checks++;
    if ({bus.o_xk_tag_valid, bus.o_busy, bus.o_ovf} !== 3'b000 || beat_data.size() != 0) begin
      n_fail++; $display("[TB] FAIL after_reset: got tagv/busy/ovf %b beats %0d expected 000 and 0",
                          {bus.o_xk_tag_valid, bus.o_busy, bus.o_ovf}, beat_data.size());
    end
  endtask

  initial begin
    zero_inputs();
    clear_tb();
    $display("[TB] start");
    test_reset();
    test_single_frame();
    test_round_robin();
    test_len_err();
    test_fifo_full();
    test_back_to_back();
    test_random_stall();
    test_ovf_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
